muntjac_metadata_tracker: RTL
=============================

// Module: muntjac_metadata_tracker
// PURPOSE
//  Upstream stage of the metadata state table. Holds an 8-bit metadata state per tracked entry,
//  queues metadata events from the pipeline, reads each event's current state, drives the
//  combinational table, writes the returned next state back and reports table exceptions.
// PARAMETERS
//  NUM_ENTRIES  32  tracked entries; IDX_W = $clog2(NUM_ENTRIES)
//  FIFO_DEPTH   4   event queue depth, power of 2, >= 2
// PORTS
//  clk_i            in   1      clock
//  rst_ni           in   1      asynchronous active-low reset
//  clear_i          in   1      synchronous flush: all entries to 0, queue/pipe/exception emptied
//  evt_valid_i      in   1      event request
//  evt_ready_o      out  1      event accepted when valid&&ready
//  evt_idx_i        in   IDX_W  target entry
//  evt_type_i       in   4      event code (load/store/uevt0/uevt1)
//  tbl_valid_o      out  1      table lookup valid
//  tbl_state_o      out  8      current state to table
//  tbl_event_o      out  4      event to table
//  tbl_state_i      in   8      next state from table (combinational return)
//  tbl_exception_i  in   1      table flags exception for this lookup
//  exc_valid_o      out  1      exception pending
//  exc_idx_o        out  IDX_W  entry that raised it
//  exc_state_o      out  8      state that was written back for it
//  exc_ack_i        in   1      consumer acknowledge, clears exc_valid_o
//  rd_idx_i         in   IDX_W  debug/inspection read index
//  rd_state_o       out  8      array[rd_idx_i], combinational, post-writeback view
//  busy_o           out  1      queue non-empty or any stage valid
// BEHAVIOUR
//  Reset: entries=0, queue empty, R/T stages invalid; evt_ready_o=1, tbl_valid_o=0, tbl_state_o=0,
//   tbl_event_o=0, exc_valid_o=0, exc_idx_o=0, exc_state_o=0, busy_o=0.
//  Input: evt_ready_o = !full (no pass-through when full). evt_type_i >= NUM_EVENTS: accepted, dropped.
//  Pipeline: cycle N accept -> N+1 head popped into R (state read from array) -> N+2 T stage
//   drives tbl_*_o from R registers, writes tbl_state_i to array at end of N+2 -> visible N+3.
//   Min latency accept-to-writeback 3 edges; throughput 1 event/cycle absent stalls.
//  Pop occurs when queue non-empty and R is free or advancing into T.
//  Hazard: pop idx == T idx with T writing this cycle -> see CONFIGURATION.
//  Exception: T lookup with tbl_exception_i and exc_valid_o=0 -> writeback as normal, capture
//   idx/state, exc_valid_o=1 next cycle, held until exc_ack_i. If exc_valid_o=1 already, T stalls
//   (no writeback, tbl_* held stable, R and queue back-pressure) until the ack cycle; ack and new
//   exception in same cycle -> new exception captured, exc_valid_o stays 1.
//  Simultaneous push+pop when full: push refused (ready low). Pointers wrap modulo FIFO_DEPTH.
//  clear_i: highest priority below reset; concurrent push dropped, T writeback suppressed.
//  rst_ni low mid-operation: all state lost, outputs to reset values asynchronously.
// CONFIGURATION
//  MUNTJAC_METADATA_FWD_EN defined: on hazard, R captures tbl_state_i from T (bypass); no bubble.
//  Not defined: on hazard pop is held one cycle, R re-reads the written array next cycle (1 bubble).
//  Architectural results identical either way; only timing differs.
// STRUCTURE
//  muntjac_metadata_pkg: META_STATE_W=8, META_EVT_W=4, NUM_EVENTS=4, META_STATE_RESET=8'd0,
//   event enum EVT_LOAD=0, EVT_STORE=1, EVT_UEVT0=2, EVT_UEVT1=3, metadata_evt_t struct {idx,type}.
//  Sub-module muntjac_metadata_event_fifo (FIFO_DEPTH x metadata_evt_t, valid/ready in, pop out).
//  Entry array, R/T stage registers, hazard/forward and exception capture in this module.
// TESTING (bench uses real table; stub table for exception cases)
//  1 Reset; LOAD on idx 3 -> tbl_state_o=0 at N+2, rd_state_o(3)=1 at N+3, busy_o=0 after.
//  2 Back-to-back LOAD,STORE idx 5 -> final 2; FWD_EN: no bubble, else exactly 1 bubble.
//  3 Hold ready-sink... fill queue: 4 pushes with table stall -> evt_ready_o=0 on 5th, none lost.
//  4 Stub exception on idx 7 -> exc_valid_o=1, exc_idx_o=7; second exception stalls T until ack.
//  5 clear_i with queue holding 3 events -> all entries 0, busy_o=0, exc_valid_o=0 next cycle.
//  6 evt_type_i=4 accepted, no tbl_valid_o, array unchanged; rst_ni pulse mid-stream -> reset values.

Source files
------------

// File: rtl/muntjac_metadata_pkg.sv
// Shared types and constants for the metadata state tracker and its event queue.
package muntjac_metadata_pkg;

    localparam int unsigned META_STATE_W   = 8;
    localparam int unsigned META_EVT_W     = 4;
    localparam int unsigned NUM_EVENTS     = 4;
    localparam int unsigned META_IDX_MAX_W = 8;

    localparam logic [META_STATE_W-1:0] META_STATE_RESET = 8'd0;

    typedef enum logic [META_EVT_W-1:0] {
        EVT_LOAD  = 4'd0,
        EVT_STORE = 4'd1,
        EVT_UEVT0 = 4'd2,
        EVT_UEVT1 = 4'd3
    } metadata_evt_e;

    typedef struct packed {
        logic [META_IDX_MAX_W-1:0] idx;
        metadata_evt_e             evt_type;
    } metadata_evt_t;

    function automatic logic evt_is_valid(input logic [META_EVT_W-1:0] code);
        return 32'(code) < NUM_EVENTS;
    endfunction

endpackage

// File: rtl/muntjac_metadata_event_fifo.sv
// Event queue in front of the tracker pipeline; DEPTH must be a power of two >= 2.
module muntjac_metadata_event_fifo
    import muntjac_metadata_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  metadata_evt_t push_data_i,
    input  logic          pop_i,
    output logic          pop_valid_o,
    output metadata_evt_t pop_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    metadata_evt_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push;
    logic             pop;

    assign push_ready_o = count_q != (PTR_W+1)'(DEPTH);
    assign pop_valid_o  = count_q != '0;
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign push         = push_valid_i && push_ready_o && !clear_i;
    assign pop          = pop_i && pop_valid_o && !clear_i;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/muntjac_metadata_tracker.sv
// Metadata state tracker: queue -> R (array read) -> table lookup/writeback.
// Define MUNTJAC_METADATA_FWD_EN to bypass writeback data into R instead of a one-cycle bubble.
module muntjac_metadata_tracker
    import muntjac_metadata_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    evt_valid_i,
    output logic                    evt_ready_o,
    input  logic [IDX_W-1:0]        evt_idx_i,
    input  logic [META_EVT_W-1:0]   evt_type_i,
    output logic                    tbl_valid_o,
    output logic [META_STATE_W-1:0] tbl_state_o,
    output logic [META_EVT_W-1:0]   tbl_event_o,
    input  logic [META_STATE_W-1:0] tbl_state_i,
    input  logic                    tbl_exception_i,
    output logic                    exc_valid_o,
    output logic [IDX_W-1:0]        exc_idx_o,
    output logic [META_STATE_W-1:0] exc_state_o,
    input  logic                    exc_ack_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [META_STATE_W-1:0] rd_state_o,
    output logic                    busy_o
);

    metadata_evt_t push_data;
    metadata_evt_t head;
    logic          fifo_push_valid;
    logic          fifo_valid;
    logic          pop;
    logic [IDX_W-1:0] head_idx;
    logic          unused_head_idx;

    logic [META_STATE_W-1:0] mem_q [NUM_ENTRIES];

    logic                    r_valid_q, r_valid_d;
    logic [IDX_W-1:0]        r_idx_q, r_idx_d;
    metadata_evt_e           r_evt_q, r_evt_d;
    logic [META_STATE_W-1:0] r_state_q, r_state_d;

    logic                    exc_valid_q, exc_valid_d;
    logic [IDX_W-1:0]        exc_idx_q, exc_idx_d;
    logic [META_STATE_W-1:0] exc_state_q, exc_state_d;

    logic t_stall;
    logic t_write;
    logic hazard;

    // Unknown event codes are acknowledged but never enter the queue.
    assign fifo_push_valid = evt_valid_i && evt_is_valid(evt_type_i) && !clear_i;
    assign push_data       = '{idx: META_IDX_MAX_W'(evt_idx_i), evt_type: metadata_evt_e'(evt_type_i)};
    assign head_idx        = IDX_W'(head.idx);
    assign unused_head_idx = ^head.idx;

    muntjac_metadata_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .push_valid_i (fifo_push_valid),
        .push_ready_o (evt_ready_o),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .pop_valid_o  (fifo_valid),
        .pop_data_o   (head)
    );

    always_comb begin
        t_stall = r_valid_q && tbl_exception_i && exc_valid_q && !exc_ack_i;
        t_write = r_valid_q && !t_stall && !clear_i;
        hazard  = fifo_valid && t_write && (head_idx == r_idx_q);
`ifdef MUNTJAC_METADATA_FWD_EN
        pop     = fifo_valid && !t_stall && !clear_i;
`else
        pop     = fifo_valid && !t_stall && !hazard && !clear_i;
`endif
    end

    always_comb begin
        r_valid_d = r_valid_q;
        r_idx_d   = r_idx_q;
        r_evt_d   = r_evt_q;
        r_state_d = r_state_q;
        if (clear_i) begin
            r_valid_d = 1'b0;
        end else if (pop) begin
            r_valid_d = 1'b1;
            r_idx_d   = head_idx;
            r_evt_d   = head.evt_type;
            r_state_d = mem_q[head_idx];
`ifdef MUNTJAC_METADATA_FWD_EN
            if (hazard) r_state_d = tbl_state_i;
`endif
        end else if (!t_stall) begin
            r_valid_d = 1'b0;
        end
    end

    // A fresh exception in the ack cycle replaces the one being acknowledged.
    always_comb begin
        exc_valid_d = exc_valid_q;
        exc_idx_d   = exc_idx_q;
        exc_state_d = exc_state_q;
        if (clear_i) begin
            exc_valid_d = 1'b0;
            exc_idx_d   = '0;
            exc_state_d = '0;
        end else if (t_write && tbl_exception_i) begin
            exc_valid_d = 1'b1;
            exc_idx_d   = r_idx_q;
            exc_state_d = tbl_state_i;
        end else if (exc_ack_i) begin
            exc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q   <= 1'b0;
            r_idx_q     <= '0;
            r_evt_q     <= EVT_LOAD;
            r_state_q   <= META_STATE_RESET;
            exc_valid_q <= 1'b0;
            exc_idx_q   <= '0;
            exc_state_q <= '0;
        end else begin
            r_valid_q   <= r_valid_d;
            r_idx_q     <= r_idx_d;
            r_evt_q     <= r_evt_d;
            r_state_q   <= r_state_d;
            exc_valid_q <= exc_valid_d;
            exc_idx_q   <= exc_idx_d;
            exc_state_q <= exc_state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= META_STATE_RESET;
        end else if (clear_i) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= META_STATE_RESET;
        end else if (t_write) begin
            mem_q[r_idx_q] <= tbl_state_i;
        end
    end

    assign tbl_valid_o = r_valid_q;
    assign tbl_state_o = r_state_q;
    assign tbl_event_o = r_evt_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_idx_o   = exc_idx_q;
    assign exc_state_o = exc_state_q;
    assign rd_state_o  = mem_q[rd_idx_i];
    assign busy_o      = fifo_valid || r_valid_q;

endmodule
